// File: rtl/ser_word_arbiter_pkg.sv
// Shared constants and types for the serializer word-slot scheduler.
// The serializer uses the same phase constants so the two counters agree on slot timing.
package ser_word_arbiter_pkg;
  typedef logic [4:0] ph_t;

  localparam ph_t PH_RESET  = 5'b11111;
  localparam ph_t PH_DECIDE = 5'b00010;
  localparam ph_t PH_LOAD   = 5'b00001;

  localparam logic [31:0] IDLE_WORD_DEF = 32'h3C3C_3C3C;
  localparam logic [31:0] SYNC_WORD_DEF = 32'hF0F0_0F0F;

  localparam int SLOT_CNT_W = 11;
endpackage

// File: rtl/ser_word_arbiter_rr_arbiter_n.sv
// Combinational round-robin grant: the search starts just above the last granted
// index and wraps, giving one-hot and encoded outputs.
module rr_arbiter_n
  import ser_word_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      idx,
  output logic            any
);
  always_comb begin
    gnt = '0;
    idx = last;
    any = 1'b0;
    // Indices above the last grant first, then the wrapped part up to and including it.
    for (int j = 0; j < NREQ; j++) begin
      if (!any && req[j] && (j > int'(last))) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = 3'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!any && req[j] && (j <= int'(last))) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = 3'(j);
      end
    end
  end
endmodule

// File: rtl/ser_word_arbiter.sv
// Word-slot scheduler feeding the 32:1 serializer: one word decision every 32 CLKBit.
// Optional SER_SYNC_INSERT_EN adds automatic SYNC insertion every SYNC_PERIOD slots.
module ser_word_arbiter
  import ser_word_arbiter_pkg::*;
#(
  parameter int          NREQ        = 2,
  parameter logic [31:0] IDLE_WORD   = IDLE_WORD_DEF,
  parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter int          SYNC_PERIOD = 1024
) (
  input  logic                 CLKBit,
  input  logic                 RSTn,
  input  logic                 Enable,
  input  logic                 SyncReq,
  input  logic [NREQ-1:0]      ReqValid,
  input  logic [32*NREQ-1:0]   ReqData,
  output logic [NREQ-1:0]      ReqReady,
  output logic [31:0]          WordOut,
  output logic [2:0]           GrantIdx,
  output logic                 SlotStrobe,
  output logic [15:0]          WordCnt
);
  ph_t             ph, ph_nxt;
  logic            decide, sync_pend, send_sync, any, slot_wrap;
  logic [NREQ-1:0] gnt;
  logic [2:0]      idx;
  logic [31:0]     sel_word;

  // The decision edge is the one that moves the phase onto PH_DECIDE, so the
  // serializer sees a full cycle of setup before its PH_LOAD edge.
  assign ph_nxt    = ph - 5'd1;
  assign decide    = (ph_nxt == PH_DECIDE);
  assign send_sync = sync_pend | SyncReq;

  rr_arbiter_n #(.NREQ(NREQ)) u_rr (
    .req (ReqValid),
    .last(GrantIdx),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) sel_word = sel_word | ReqData[32*i +: 32];
  end

`ifdef SER_SYNC_INSERT_EN
  localparam logic [SLOT_CNT_W-1:0] SLOT_LAST = SLOT_CNT_W'(SYNC_PERIOD - 1);
  logic [SLOT_CNT_W-1:0] slot_cnt;

  assign slot_wrap = decide & ~send_sync & ((slot_cnt + 1'b1) == SLOT_LAST);

  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn)                       slot_cnt <= '0;
    else if (decide) begin
      if (send_sync || slot_wrap)    slot_cnt <= '0;
      else                           slot_cnt <= slot_cnt + 1'b1;
    end
  end
`else
  assign slot_wrap = 1'b0;
`endif

  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      ph         <= PH_RESET;
      WordOut    <= IDLE_WORD;
      ReqReady   <= '0;
      GrantIdx   <= 3'(NREQ - 1);
      SlotStrobe <= 1'b0;
      WordCnt    <= '0;
      sync_pend  <= 1'b0;
    end else begin
      ph         <= ph_nxt;
      ReqReady   <= '0;
      SlotStrobe <= 1'b0;
      if (decide) begin
        SlotStrobe <= 1'b1;
        // Pending is zero whenever sync is not sent, so only the auto-insert can set it here.
        sync_pend  <= slot_wrap;
        if (send_sync) begin
          WordOut <= SYNC_WORD;
        end else if (Enable && any) begin
          WordOut  <= sel_word;
          ReqReady <= gnt;
          GrantIdx <= idx;
          WordCnt  <= WordCnt + 16'd1;
        end else begin
          WordOut <= IDLE_WORD;
        end
      end else if (SyncReq) begin
        sync_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ser_word_arbiter.sv
// Randomized bench for ser_word_arbiter with a slot-level reference model and
// hand-computed literal checks for reset, alternation, single requester, sync and mid-slot reset.
module tb_ser_word_arbiter;
  localparam int NREQ = 2;
  localparam logic [31:0] IDLE = 32'h3C3C_3C3C;
  localparam logic [31:0] SYNC = 32'hF0F0_0F0F;
  localparam logic [31:0] WA   = 32'hAAAA_0000;
  localparam logic [31:0] WB   = 32'hBBBB_0001;
`ifdef SER_SYNC_INSERT_EN
  localparam int SP = 4;
`else
  localparam int SP = 1024;
`endif

  logic                CLKBit = 1'b0;
  logic                RSTn = 1'b0;
  logic                Enable = 1'b0;
  logic                SyncReq = 1'b0;
  logic [NREQ-1:0]     ReqValid = '0;
  logic [32*NREQ-1:0]  ReqData = '0;
  logic [NREQ-1:0]     ReqReady;
  logic [31:0]         WordOut;
  logic [2:0]          GrantIdx;
  logic                SlotStrobe;
  logic [15:0]         WordCnt;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 CLKBit = ~CLKBit;

  ser_word_arbiter #(.NREQ(NREQ), .SYNC_PERIOD(SP)) dut (
    .CLKBit(CLKBit), .RSTn(RSTn), .Enable(Enable), .SyncReq(SyncReq),
    .ReqValid(ReqValid), .ReqData(ReqData), .ReqReady(ReqReady),
    .WordOut(WordOut), .GrantIdx(GrantIdx), .SlotStrobe(SlotStrobe), .WordCnt(WordCnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slots are counted in edges since reset release, not by a phase register.
  int              e;
  int              m_since;
  int              win;
  logic [31:0]     m_word;
  logic [NREQ-1:0] m_rdy;
  logic [2:0]      m_gi;
  logic            m_stb, m_pend;
  logic [15:0]     m_cnt;

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always_comb win = Enable ? pick(ReqValid, int'(m_gi)) : -1;

  always @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      e <= 0; m_word <= IDLE; m_rdy <= '0; m_gi <= 3'(NREQ - 1);
      m_stb <= 1'b0; m_cnt <= '0; m_pend <= 1'b0; m_since <= 0;
    end else begin
      e <= e + 1;
      m_rdy <= '0;
      m_stb <= 1'b0;
      if ((e + 1) >= 29 && ((e + 1 - 29) % 32) == 0) begin
        m_stb <= 1'b1;
        if (m_pend || SyncReq) begin
          m_word <= SYNC; m_pend <= 1'b0; m_since <= 0;
        end else begin
          if (win >= 0) begin
            m_word <= ReqData[32*win +: 32];
            m_rdy <= NREQ'(1) << win;
            m_gi <= 3'(win);
            m_cnt <= m_cnt + 16'd1;
          end else begin
            m_word <= IDLE;
          end
`ifdef SER_SYNC_INSERT_EN
          if (m_since + 1 == SP - 1) begin m_pend <= 1'b1; m_since <= 0; end
          else m_since <= m_since + 1;
`endif
        end
      end else if (SyncReq) begin
        m_pend <= 1'b1;
      end
    end
  end

  always @(negedge CLKBit) begin
    if (cmp_on) begin
      chk("m_WordOut", WordOut, m_word);
      chk("m_ReqReady", 32'(ReqReady), 32'(m_rdy));
      chk("m_GrantIdx", 32'(GrantIdx), 32'(m_gi));
      chk("m_SlotStrobe", 32'(SlotStrobe), 32'(m_stb));
      chk("m_WordCnt", 32'(WordCnt), 32'(m_cnt));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLKBit);
    #1;
  endtask

  task automatic wait_slot();
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!SlotStrobe && n < 40);
    chk("slot_seen", 32'(SlotStrobe), 32'd1);
  endtask

  logic [31:0] t2w [3] = '{WA, WB, WA};
  logic [1:0]  t2r [3] = '{2'b01, 2'b10, 2'b01};

  initial begin
    repeat (3) @(negedge CLKBit);
    cmp_on = 1'b1;
    chk("rst_word", WordOut, IDLE);
    chk("rst_gi", 32'(GrantIdx), 32'd1);
    RSTn = 1'b1;

    // Idle slots: strobes on edges 29, 61, 93 after release.
    tick(28); chk("strobe_pre", 32'(SlotStrobe), 32'd0);
    tick(1);  chk("strobe_e29", 32'(SlotStrobe), 32'd1);
    chk("idle_rdy", 32'(ReqReady), 32'd0);
    tick(32); chk("strobe_e61", 32'(SlotStrobe), 32'd1);
    tick(32); chk("strobe_e93", 32'(SlotStrobe), 32'd1);
    chk("idle_word", WordOut, IDLE);

    // Two requesters held valid: alternate A, B, A.
    ReqData = {WB, WA}; ReqValid = 2'b11; Enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_slot();
      chk("alt_word", WordOut, t2w[i]);
      chk("alt_rdy", 32'(ReqReady), 32'(t2r[i]));
    end
    chk("alt_cnt", 32'(WordCnt), 32'd3);

    // Only requester 1 valid.
    ReqValid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      wait_slot();
      chk("r1_word", WordOut, WB);
      chk("r1_rdy", 32'(ReqReady), 32'b10);
    end
    chk("r1_gi", 32'(GrantIdx), 32'd1);
    chk("r1_cnt", 32'(WordCnt), 32'd7);

    // Sync pulse mid-slot pre-empts one slot without moving the pointer.
    ReqValid = 2'b11;
    wait_slot(); chk("pre_sync_word", WordOut, WA);
    tick(18); SyncReq = 1'b1; tick(1); SyncReq = 1'b0;
    wait_slot();
    chk("sync_word", WordOut, SYNC);
    chk("sync_rdy", 32'(ReqReady), 32'd0);
    chk("sync_gi", 32'(GrantIdx), 32'd0);
    wait_slot(); chk("post_sync_word", WordOut, WB);

    // Randomized traffic.
    repeat (1500) begin
      tick(1);
      if ($urandom_range(0, 3) == 0) ReqValid = NREQ'($urandom);
      if ($urandom_range(0, 7) == 0) ReqData = {$urandom, $urandom};
      Enable  = ($urandom_range(0, 7) != 0);
      SyncReq = ($urandom_range(0, 39) == 0);
    end

    // Reset at phase 7 aborts the slot.
    SyncReq = 1'b0; Enable = 1'b1; ReqValid = 2'b11; ReqData = {WB, WA};
    wait_slot();
    tick(27);
    RSTn = 1'b0;
    #1;
    chk("mid_rst_word", WordOut, IDLE);
    chk("mid_rst_cnt", 32'(WordCnt), 32'd0);
    chk("mid_rst_stb", 32'(SlotStrobe), 32'd0);
    chk("mid_rst_rdy", 32'(ReqReady), 32'd0);
    @(negedge CLKBit);
    RSTn = 1'b1;
    tick(28); chk("rel_strobe_pre", 32'(SlotStrobe), 32'd0);
    tick(1);  chk("rel_strobe_e29", 32'(SlotStrobe), 32'd1);
    chk("rel_word", WordOut, WA);
    chk("rel_cnt", 32'(WordCnt), 32'd1);
    repeat (3) wait_slot();
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
